conv_mac_engine: RTL and testbench

- Convolution datapath/control stage that consumes the registered full-size length (sizex + sizey - 1) produced by the size stage, together with sizex and sizey.
- On start, it computes the full linear convolution z[i] = sum over k of x[k]*y[i-k] for i = 0..size_full-1.
- It reads x and y from synchronous-read memories and writes each z sample to the result memory.
- It asserts done when the last sample is written.

---
 rtl/conv_mac_engine.sv | 147 ++++++++++++++
 tb/tb_conv_mac_engine.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: full linear convolution z = x * y over sync-read memories.
// Ports: clk/rstn, start_i + sizes in; x/y addr out, data in; z write port, busy_o, done_o out.
module conv_mac_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [4:0]        sizex_i,
    input  logic [4:0]        sizey_i,
    input  logic [5:0]        size_full_i,
    input  logic [DATA_W-1:0] memx_data_i,
    input  logic [DATA_W-1:0] memy_data_i,
    output logic [4:0]        memx_addr_o,
    output logic [4:0]        memy_addr_o,
    output logic [5:0]        memz_addr_o,
    output logic [ACC_W-1:0]  memz_data_o,
    output logic              memz_we_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SCAN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [4:0]          r_sx;
    logic [4:0]          r_sy;
    logic [5:0]          r_sf;
    logic [5:0]          r_i;
    logic [5:0]          r_k;
    logic [ACC_W-1:0]    r_acc;
    logic                r_vld;
    logic [5:0]          r_zaddr;
    logic [ACC_W-1:0]    r_zdata;

    logic [5:0]          w_diff;
    logic                w_tap;
    logic                w_last_k;
    logic                w_last_i;
    logic [2*DATA_W-1:0] w_mul;

    assign w_diff   = r_i - r_k;
    // Tap lands inside y only when 0 <= i-k < sizey.
    assign w_tap    = (r_state == S_SCAN) && (r_i >= r_k)
                      && (w_diff < {1'b0, r_sy});
    assign w_last_k = (r_k == ({1'b0, r_sx} - 6'd1));
    assign w_last_i = (r_i == (r_sf - 6'd1));
    assign w_mul    = {{DATA_W{1'b0}}, memx_data_i}
                      * {{DATA_W{1'b0}}, memy_data_i};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        memx_addr_o = '0;
        memy_addr_o = '0;
        memz_we_o   = 1'b0;
        memz_addr_o = r_zaddr;
        memz_data_o = r_zdata;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    if (sizex_i == 5'd0 || sizey_i == 5'd0) w_next = S_DONE;
                    else                                    w_next = S_INIT;
                end
            end
            S_INIT: w_next = S_SCAN;
            S_SCAN: begin
                memx_addr_o = r_k[4:0];
                memy_addr_o = w_diff[4:0];
                if (w_last_k) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: begin
                memz_we_o   = 1'b1;
                memz_addr_o = r_i;
                memz_data_o = r_acc;
                w_next      = w_last_i ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sx    <= '0;
            r_sy    <= '0;
            r_sf    <= '0;
            r_i     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_vld   <= 1'b0;
            r_zaddr <= '0;
            r_zdata <= '0;
        end else begin
            // Valid is delayed to line up with the sync-read data.
            r_vld <= w_tap;
            if (r_vld) r_acc <= r_acc + {{(ACC_W-2*DATA_W){1'b0}}, w_mul};
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_sx <= sizex_i;
                        r_sy <= sizey_i;
                        r_sf <= size_full_i;
                    end
                end
                S_INIT: begin
                    r_i   <= '0;
                    r_k   <= '0;
                    r_acc <= '0;
                end
                S_SCAN: r_k <= r_k + 6'd1;
                S_WRITE: begin
                    r_zaddr <= r_i;
                    r_zdata <= r_acc;
                    if (!w_last_i) begin
                        r_i   <= r_i + 6'd1;
                        r_k   <= '0;
                        r_acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: table-driven check of conv_mac_engine results and timing.
// Models the x/y sync-read memories and captures every z write.
module tb_conv_mac_engine;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  sizex_i = '0;
    logic [4:0]  sizey_i = '0;
    logic [5:0]  size_full_i = '0;
    logic [7:0]  memx_data_i = '0;
    logic [7:0]  memy_data_i = '0;
    logic [4:0]  memx_addr_o;
    logic [4:0]  memy_addr_o;
    logic [5:0]  memz_addr_o;
    logic [31:0] memz_data_o;
    logic        memz_we_o;
    logic        busy_o;
    logic        done_o;

    conv_mac_engine #(.DATA_W(8), .ACC_W(32)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i),
        .sizex_i(sizex_i), .sizey_i(sizey_i), .size_full_i(size_full_i),
        .memx_data_i(memx_data_i), .memy_data_i(memy_data_i),
        .memx_addr_o(memx_addr_o), .memy_addr_o(memy_addr_o),
        .memz_addr_o(memz_addr_o), .memz_data_o(memz_data_o),
        .memz_we_o(memz_we_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  mx [32];
    logic [7:0]  my [32];
    logic [31:0] zcap [64];

    always @(posedge clk) begin
        memx_data_i <= mx[memx_addr_o];
        memy_data_i <= my[memy_addr_o];
    end

    typedef struct {
        int               sx;
        int               sy;
        int               fill;
        logic [3:0][7:0]  x;
        logic [3:0][7:0]  y;
        int               nw;
        int               dcyc;
        int               nchk;
        logic [2:0][5:0]  zi;
        logic [2:0][31:0] zv;
    } vec_t;

    vec_t vecs [6];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int j = 0; j < 32; j++) begin
            mx[j] = (v.fill != 0) ? 8'(v.fill) : ((j < 4) ? v.x[j] : 8'd0);
            my[j] = (v.fill != 0) ? 8'(v.fill) : ((j < 4) ? v.y[j] : 8'd0);
        end
        for (int j = 0; j < 64; j++) zcap[j] = '0;
        sizex_i     = 5'(v.sx);
        sizey_i     = 5'(v.sy);
        size_full_i = 6'(v.sx + v.sy - 1);
    endtask

    task automatic run(input vec_t v, input bit perturb, input string tag);
        int n, wcnt, aerr, gap, dn, post;
        load(v);
        wcnt = 0; aerr = 0; gap = 0; dn = -1; post = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        n = 0;
        while (dn < 0 && n < 4000) begin
            @(negedge clk);
            n++;
            start_i = 1'b0;
            if (!busy_o) gap++;
            if (memz_we_o) begin
                if (memz_addr_o != 6'(wcnt)) aerr++;
                zcap[memz_addr_o] = memz_data_o;
                wcnt++;
            end
            if (perturb && n == 3) begin
                start_i = 1'b1;
                sizex_i = 5'd5;
            end
            if (done_o) begin
                dn = n;
                if (perturb) begin
                    start_i     = 1'b1;
                    sizex_i     = 5'd1;
                    sizey_i     = 5'd1;
                    size_full_i = 6'd1;
                end
            end
        end
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (busy_o || memz_we_o || done_o) post++;
        end
        chk({tag, " done_cycle"}, dn, v.dcyc);
        chk({tag, " writes"}, wcnt, v.nw);
        chk({tag, " addr_order_errs"}, aerr, 0);
        chk({tag, " busy_gaps"}, gap, 0);
        chk({tag, " activity_after_done"}, post, 0);
        for (int c = 0; c < v.nchk; c++)
            chk($sformatf("%s z[%0d]", tag, v.zi[c]), zcap[v.zi[c]], v.zv[c]);
    endtask

    task automatic rst_mid(input vec_t v);
        int n, wcnt, bad;
        load(v);
        wcnt = 0; bad = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            n++;
            if (memz_we_o) wcnt++;
        end
        chk("rst_mid writes_before", wcnt, 1);
        rstn = 1'b0;
        #1;
        chk("rst_mid outputs_zero",
            {memx_addr_o, memy_addr_o, memz_addr_o, memz_data_o,
             memz_we_o, busy_o, done_o}, 0);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (memz_we_o || done_o || busy_o) bad++;
        end
        chk("rst_mid quiet", bad, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{sx: 3, sy: 2, fill: 0,
                    x: {8'd0, 8'd3, 8'd2, 8'd1}, y: {8'd0, 8'd0, 8'd1, 8'd1},
                    nw: 4, dcyc: 22, nchk: 3,
                    zi: {6'd3, 6'd2, 6'd1}, zv: {32'd3, 32'd5, 32'd3}};
        vecs[1] = '{sx: 1, sy: 1, fill: 0,
                    x: {8'd0, 8'd0, 8'd0, 8'd7}, y: {8'd0, 8'd0, 8'd0, 8'd9},
                    nw: 1, dcyc: 5, nchk: 1,
                    zi: {6'd0, 6'd0, 6'd0}, zv: {32'd0, 32'd0, 32'd63}};
        vecs[2] = '{sx: 31, sy: 31, fill: 255,
                    x: '0, y: '0,
                    nw: 61, dcyc: 2015, nchk: 3,
                    zi: {6'd60, 6'd30, 6'd0},
                    zv: {32'd65025, 32'd2015775, 32'd65025}};
        vecs[3] = '{sx: 0, sy: 4, fill: 0,
                    x: '0, y: '0,
                    nw: 0, dcyc: 1, nchk: 0,
                    zi: '0, zv: '0};
        vecs[4] = '{sx: 2, sy: 3, fill: 0,
                    x: {8'd0, 8'd0, 8'd3, 8'd2}, y: {8'd0, 8'd4, 8'd0, 8'd1},
                    nw: 4, dcyc: 18, nchk: 3,
                    zi: {6'd3, 6'd2, 6'd0}, zv: {32'd12, 32'd8, 32'd2}};
        vecs[5] = '{sx: 4, sy: 0, fill: 0,
                    x: '0, y: '0,
                    nw: 0, dcyc: 1, nchk: 0,
                    zi: '0, zv: '0};

        for (int j = 0; j < 32; j++) begin
            mx[j] = '0;
            my[j] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset outputs_zero",
            {memx_addr_o, memy_addr_o, memz_addr_o, memz_data_o,
             memz_we_o, busy_o, done_o}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 6; r++)
            run(vecs[r], 1'b0, $sformatf("vec%0d", r));

        run(vecs[0], 1'b1, "perturbed");
        run(vecs[0], 1'b0, "relaunch");
        rst_mid(vecs[0]);
        run(vecs[0], 1'b0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
